spi_ram_master: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 27 ++
 rtl/spi_ram_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_ram_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: op codes, master states and widths shared
// by the SPI/RAM master and the slave wrapper.
`timescale 1ns/1ps
package spi_ram_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } spi_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_CMD,
      ST_SHIFT,
      ST_HOLD,
      ST_WAIT,
      ST_READ,
      ST_GAP
   } mst_state_e;

endpackage

// File: rtl/spi_ram_master.sv
// spi_ram_master: turns host ops into SPI/RAM frames and
// collects the read byte returned on MISO.
`timescale 1ns/1ps
module spi_ram_master
   import spi_ram_pkg::*;
#(
   parameter int RD_LAT   = 3,
   parameter int END_HOLD = 2,
   parameter int IDLE_GAP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(END_HOLD);
   localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(IDLE_GAP - 1);
   localparam logic [CNT_W-1:0] C_BITS = CNT_W'(FRAME_W - 2);
   localparam logic [CNT_W-1:0] C_RDB  = CNT_W'(DATA_W);

   mst_state_e         r_state, w_state_nxt;
   logic [FRAME_W-1:0] r_frame, w_frame_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0]  r_shift, w_shift_nxt;
   logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_nxt;
   logic               r_ss_n, w_ss_n_nxt;
   logic               r_mosi, w_mosi_nxt;
   logic               r_rsp_valid, w_rsp_valid_nxt;
   logic               r_rsp_err, w_rsp_err_nxt;
   logic               r_rd_done, w_rd_done_nxt;
   logic               w_ready;
   logic               w_accept;
   spi_op_e            w_op;

   // A finished frame may be followed at once by the next
   // one when the gap count has already run out.
   assign w_ready  = (r_state == ST_IDLE) ||
                     (r_state == ST_GAP && r_cnt == '0);
   assign w_accept = req_valid && w_ready;
   assign w_op     = spi_op_e'(r_frame[FRAME_W-1 -: 2]);

   // State and output registers, cleared by async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_frame     <= '0;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_rsp_data  <= '0;
         r_ss_n      <= 1'b1;
         r_mosi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rd_done   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame     <= w_frame_nxt;
         r_cnt       <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_ss_n      <= w_ss_n_nxt;
         r_mosi      <= w_mosi_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rd_done   <= w_rd_done_nxt;
      end
   end

   // Frame sequencing: next state and next register values.
   always_comb begin
      w_state_nxt     = r_state;
      w_frame_nxt     = r_frame;
      w_cnt_nxt       = r_cnt;
      w_shift_nxt     = r_shift;
      w_rsp_data_nxt  = '0;
      w_ss_n_nxt      = r_ss_n;
      w_mosi_nxt      = r_mosi;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = 1'b0;
      w_rd_done_nxt   = r_rd_done;
      unique case (r_state)
         ST_IDLE, ST_GAP: begin
            if (r_state == ST_GAP) begin
               if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
               else             w_state_nxt = ST_IDLE;
            end
            if (w_accept) begin
               if (req_op == OP_RD_DATA && !r_rd_done) begin
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_err_nxt   = 1'b1;
                  w_state_nxt     = ST_IDLE;
               end else begin
                  w_frame_nxt = {req_op,
                     (req_op == OP_RD_DATA) ? '0 : req_data};
                  w_ss_n_nxt  = 1'b0;
                  w_mosi_nxt  = 1'b0;
                  w_state_nxt = ST_SEL;
               end
            end
         end
         ST_SEL: begin
            w_mosi_nxt  = r_frame[FRAME_W-1];
            w_state_nxt = ST_CMD;
         end
         ST_CMD: begin
            w_mosi_nxt  = r_frame[FRAME_W-1];
            w_cnt_nxt   = C_BITS;
            w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            w_mosi_nxt = r_frame[r_cnt[3:0]];
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_op == OP_RD_DATA) begin
               w_cnt_nxt   = C_WAIT;
               w_state_nxt = ST_WAIT;
            end else begin
               w_cnt_nxt   = C_HOLD;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_mosi_nxt = 1'b0;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_ss_n_nxt      = 1'b1;
               w_rsp_valid_nxt = 1'b1;
               w_cnt_nxt       = C_GAP;
               w_state_nxt     = ST_GAP;
               if (w_op == OP_RD_ADDR) w_rd_done_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            w_mosi_nxt = 1'b0;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            w_mosi_nxt = 1'b0;
            if (r_cnt != C_RDB) begin
               w_shift_nxt = {r_shift[DATA_W-2:0], MISO};
               w_cnt_nxt   = r_cnt + 1'b1;
            end else begin
               w_ss_n_nxt      = 1'b1;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = r_shift;
               w_rd_done_nxt   = 1'b0;
               w_cnt_nxt       = C_GAP;
               w_state_nxt     = ST_GAP;
            end
         end
      endcase
   end

   assign req_ready = w_ready;
   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_data  = r_rsp_data;
   assign SS_n      = r_ss_n;
   assign MOSI      = r_mosi;

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: directed frames with hand-computed MOSI
// streams, SS_n lengths and responses.
`timescale 1ns/1ps
module tb_spi_ram_master;

   localparam int RD_LAT = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [7:0] req_data = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   spi_ram_master #(
      .RD_LAT(3), .END_HOLD(2), .IDLE_GAP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One full frame; MOSI is captured after E1..E11.
   task automatic do_frame(input string tag,
                           input logic [1:0] op,
                           input logic [7:0] data,
                           input logic [7:0] miso_b,
                           input logic [10:0] exp_mosi,
                           input int exp_low,
                           input logic [7:0] exp_rd);
      int low;
      logic [10:0] mv;
      logic bad;
      logic done;
      @(negedge clk);
      req_op = op; req_data = data; req_valid = 1'b1;
      check({tag, "_ready"}, req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_fall"}, SS_n, 0);
      low = 1; mv = '0; bad = 1'b0; done = 1'b0;
      for (int k = 1; k < 64 && !done; k++) begin
         @(posedge clk); #1;
         if (k <= 11) mv = {mv[9:0], MOSI};
         if (k >= 11 + RD_LAT && k < 11 + RD_LAT + 8)
            MISO = miso_b[7 - (k - 11 - RD_LAT)];
         else
            MISO = 1'b0;
         if (SS_n) begin
            done = 1'b1;
            check({tag, "_vld"}, rsp_valid, 1);
            check({tag, "_err"}, rsp_err, 0);
            check({tag, "_rdat"}, rsp_data, exp_rd);
         end else begin
            low++;
            if (req_ready || !busy || rsp_valid) bad = 1'b1;
         end
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_low"}, low, exp_low);
      check({tag, "_mosi"}, mv, exp_mosi);
      check({tag, "_inframe"}, bad, 0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, rsp_valid, 0);
   endtask

   // Op 11 without a prior read-address is refused at once.
   task automatic rd_reject(input string tag);
      @(negedge clk);
      req_op = 2'b11; req_data = 8'hFF; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_vld"}, rsp_valid, 1);
      check({tag, "_err"}, rsp_err, 1);
      check({tag, "_ss"}, SS_n, 1);
      check({tag, "_busy"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, rsp_valid, 0);
      check({tag, "_ss2"}, SS_n, 1);
   endtask

   initial begin
      int acc, falls, gap, hrun, rsps;
      logic prev, pend, bad;

      #12;
      check("rst_ss", SS_n, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_vld", rsp_valid, 0);
      check("rst_err", rsp_err, 0);
      check("rst_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 check("rst_ready", req_ready, 1);

      rd_reject("rd_norda");
      do_frame("wa3c", 2'b00, 8'h3C, 8'h00,
               11'b00000111100, 14, 8'h00);
      do_frame("wa12", 2'b00, 8'h12, 8'h00,
               11'b00000010010, 14, 8'h00);
      do_frame("wda5", 2'b01, 8'hA5, 8'h00,
               11'b00110100101, 14, 8'h00);
      do_frame("ra12", 2'b10, 8'h12, 8'h00,
               11'b11000010010, 14, 8'h00);
      do_frame("rdA5", 2'b11, 8'h77, 8'hA5,
               11'b11100000000, 23, 8'hA5);
      rd_reject("rd_clr");
      do_frame("ra12b", 2'b10, 8'h12, 8'h00,
               11'b11000010010, 14, 8'h00);
      do_frame("ra34", 2'b10, 8'h34, 8'h00,
               11'b11000110100, 14, 8'h00);
      do_frame("rd81", 2'b11, 8'h00, 8'h81,
               11'b11100000000, 23, 8'h81);

      // Back-to-back op 01 with valid held high.
      @(negedge clk);
      req_op = 2'b01; req_data = 8'h55; req_valid = 1'b1;
      acc = 0; falls = 0; gap = -1; hrun = 0; rsps = 0;
      prev = 1'b1; bad = 1'b0;
      for (int k = 0; k < 60; k++) begin
         pend = req_valid && req_ready;
         @(posedge clk); #1;
         if (pend) begin
            acc++;
            if (acc == 2) req_valid = 1'b0;
         end
         if (rsp_valid) rsps++;
         if (prev && !SS_n) begin
            falls++;
            if (falls == 2) gap = hrun;
         end
         if (SS_n) hrun++;
         else begin
            hrun = 0;
            if (req_ready) bad = 1'b1;
         end
         prev = SS_n;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_acc", acc, 2);
      check("b2b_falls", falls, 2);
      check("b2b_gap", gap, 1);
      check("b2b_rsps", rsps, 2);
      check("b2b_ready", bad, 0);

      // A request pulsed mid-frame is dropped.
      @(negedge clk);
      req_op = 2'b00; req_data = 8'h3C; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      falls = 1; rsps = 0; prev = SS_n;
      for (int k = 1; k < 40; k++) begin
         @(negedge clk);
         req_valid = (k == 6);
         @(posedge clk); #1;
         if (prev && !SS_n) falls++;
         if (rsp_valid) rsps++;
         prev = SS_n;
      end
      req_valid = 1'b0;
      check("busy_falls", falls, 1);
      check("busy_rsps", rsps, 1);
      check("busy_ready", req_ready, 1);

      // Reset in the middle of SHIFT.
      do_frame("ra_pre", 2'b10, 8'h12, 8'h00,
               11'b11000010010, 14, 8'h00);
      @(negedge clk);
      req_op = 2'b01; req_data = 8'hFF; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_ss", SS_n, 1);
      check("mid_mosi", MOSI, 0);
      check("mid_busy", busy, 0);
      check("mid_vld", rsp_valid, 0);
      rsps = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) rsps++;
      end
      @(negedge clk); rst_n = 1'b1;
      #1 check("mid_ready", req_ready, 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (rsp_valid || !SS_n) rsps++;
      end
      check("mid_norsp", rsps, 0);
      rd_reject("rd_afterrst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
